mem_port_arbiter: RTL

//  N-port arbiter and word assembler in front of the 16-bit asynchronous SRAM.
//  It replaces the fixed fetch/memory/VGA handler with a parametrised block.

---
 rtl/y86_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and SRAM geometry defaults.
package y86_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_ACK
   } mem_state_e;

   localparam int unsigned SRAM_DW_DEF = 16;
   localparam int unsigned SRAM_AW_DEF = 18;

   // Index width for a set of n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client request/response bus plus SRAM pin bundle of the port arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned SRAM_DW   = y86_mem_pkg::SRAM_DW_DEF,
   parameter int unsigned SRAM_AW   = y86_mem_pkg::SRAM_AW_DEF
);

   logic [NUM_PORTS-1:0]        req;
   logic [NUM_PORTS-1:0]        we;
   logic [NUM_PORTS*ADDR_W-1:0] addr;
   logic [NUM_PORTS*DATA_W-1:0] wdata;
   logic [DATA_W-1:0]           rdata;
   logic [NUM_PORTS-1:0]        ack;
   logic [NUM_PORTS-1:0]        grant;

   logic [SRAM_AW-1:0]          sram_addr;
   logic [SRAM_DW-1:0]          sram_wdata;
   logic [SRAM_DW-1:0]          sram_rdata;
   logic                        sram_drive;
   logic                        sram_we_n;
   logic                        sram_oe_n;
   logic                        sram_ce_n;
   logic                        sram_ub_n;
   logic                        sram_lb_n;

   // Client side plus the SRAM pad model.
   modport master (
      output req, we, addr, wdata, sram_rdata,
      input  rdata, ack, grant,
      input  sram_addr, sram_wdata, sram_drive,
      input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
   );

   // Arbiter side.
   modport slave (
      input  req, we, addr, wdata, sram_rdata,
      output rdata, ack, grant,
      output sram_addr, sram_wdata, sram_drive,
      output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational winner selection: round-robin from pointer+1, or fixed lowest-index priority.
module rr_arbiter #(
   parameter int unsigned NUM_PORTS = 3,
   parameter bit          RR_MODE   = 1'b1,
   localparam int unsigned PW       = y86_mem_pkg::idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        pointer,
   output logic [NUM_PORTS-1:0] winner
);

   always_comb begin
      int unsigned idx;
      logic        found;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (RR_MODE)
            idx = (32'(pointer) + 32'd1 + k) % NUM_PORTS;
         else
            idx = k;
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter and word assembler in front of a 16-bit asynchronous SRAM.
// One client word is split into little-endian halfword beats, each a SETUP then STROBE cycle.
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned SRAM_DW   = SRAM_DW_DEF,
   parameter int unsigned SRAM_AW   = SRAM_AW_DEF,
   parameter bit          RR_MODE   = 1'b1
) (
   input logic               CLOCK_50,
   input logic               RESET_N,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned BEATS     = DATA_W / SRAM_DW;
   localparam int unsigned PW        = idx_width(NUM_PORTS);
   localparam int unsigned BW        = idx_width(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   mem_state_e           state, state_n;
   logic [PW-1:0]        owner;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        win_idx;
   logic [BW-1:0]        beat;
   logic                 lat_we;
   logic [SRAM_AW-1:0]   lat_hw;
   logic [DATA_W-1:0]    lat_wdata;
   logic [DATA_W-1:0]    rdata_q;
   logic [NUM_PORTS-1:0] winner;
   logic [NUM_PORTS-1:0] owner_oh;
   logic [ADDR_W-1:0]    addr_sel;
   logic                 load;
   logic                 beat_inc;
   logic                 capture;
   logic                 ptr_upd;
   logic                 unused_addr_bits;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .RR_MODE   (RR_MODE)
   ) u_rr_arbiter (
      .req     (bus.req),
      .pointer (rr_ptr),
      .winner  (winner)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (winner[i])
            win_idx = PW'(i);
      end
   end

   assign addr_sel = bus.addr[win_idx*ADDR_W +: ADDR_W];
   // Byte-lane bit 0 and bits above the SRAM range carry no meaning here.
   assign unused_addr_bits = ^{addr_sel[ADDR_W-1:SRAM_AW+1], addr_sel[0]};

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n        = state;
      load           = 1'b0;
      beat_inc       = 1'b0;
      capture        = 1'b0;
      ptr_upd        = 1'b0;
      bus.ack        = '0;
      bus.grant      = '0;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      bus.sram_drive = 1'b0;
      bus.sram_we_n  = 1'b1;
      bus.sram_oe_n  = 1'b1;
      bus.sram_ce_n  = 1'b1;
      bus.sram_ub_n  = 1'b1;
      bus.sram_lb_n  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (|bus.req) begin
               load    = 1'b1;
               state_n = ST_SETUP;
            end
         end
         ST_SETUP, ST_STROBE: begin
            bus.grant     = owner_oh;
            bus.sram_addr = lat_hw + SRAM_AW'(beat);
            bus.sram_ce_n = 1'b0;
            bus.sram_ub_n = 1'b0;
            bus.sram_lb_n = 1'b0;
            if (lat_we) begin
               bus.sram_drive = 1'b1;
               bus.sram_wdata = lat_wdata[beat*SRAM_DW +: SRAM_DW];
            end
            if (state == ST_SETUP) begin
               state_n = ST_STROBE;
            end else begin
               if (lat_we) begin
                  bus.sram_we_n = 1'b0;
               end else begin
                  bus.sram_oe_n = 1'b0;
                  capture       = 1'b1;
               end
               beat_inc = 1'b1;
               state_n  = (beat == LAST_BEAT) ? ST_ACK : ST_SETUP;
            end
         end
         ST_ACK: begin
            bus.ack = owner_oh;
            ptr_upd = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         owner     <= '0;
         rr_ptr    <= PW'(NUM_PORTS - 1);
         beat      <= '0;
         lat_we    <= 1'b0;
         lat_hw    <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         if (load) begin
            owner     <= win_idx;
            lat_we    <= bus.we[win_idx];
            lat_hw    <= addr_sel[SRAM_AW:1];
            lat_wdata <= bus.wdata[win_idx*DATA_W +: DATA_W];
            beat      <= '0;
         end
         if (capture)
            rdata_q[beat*SRAM_DW +: SRAM_DW] <= bus.sram_rdata;
         if (beat_inc)
            beat <= beat + 1'b1;
         if (ptr_upd)
            rr_ptr <= owner;
      end
   end

   assign bus.rdata = rdata_q;

endmodule
